// File: rtl/scale_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : scale_ctrl_if
//  Description : Pixel stream bundle for scale_ctrl. It carries the input
//                pixel handshake (in_valid/in_ready/in_pixel) and the output
//                pixel handshake (out_valid/out_ready/out_pixel).
//                The master modport is the stream environment (pixel source
//                and sink). The slave modport is the scaler itself.
//  Ports       : in_valid, in_pixel, out_ready : master -> slave
//                in_ready, out_valid, out_pixel : slave  -> master
//  Revision    : 1.0  initial release
// ============================================================================
interface scale_ctrl_if #(
    parameter int PIX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_pixel;

    modport master (
        output in_valid,
        output in_pixel,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_pixel
    );

    modport slave (
        input  in_valid,
        input  in_pixel,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_pixel
    );
endinterface
`default_nettype wire

// File: rtl/scale_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : scale_ctrl
//  Description : Frame-based pixel scaler. After an accepted start, it takes
//                frame_len pixels. Each pixel is multiplied by the active
//                scale factor and saturated to PIX_W bits. The result goes
//                through a one-deep output register with a valid/ready
//                handshake. A done pulse marks normal frame completion.
//                abort returns the block to IDLE at once.
//  Ports       : clk, rst_n          clock, asynchronous active-low reset
//                px (slave)          input/output pixel handshakes
//                cfg_wr, cfg_factor  scale factor write (honoured in IDLE)
//                start, frame_len    frame start request and length
//                abort               synchronous frame abort
//                busy, done          status, done is a one-cycle pulse
//                pix_cnt             pixels accepted in the current frame
//                factor              active scale factor
//  Revision    : 1.0  initial release
// ============================================================================
module scale_ctrl #(
    parameter int PIX_W     = 8,
    parameter int CNT_W     = 16,
    parameter int SCALE_RST = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    scale_ctrl_if.slave           px,
    input  wire logic             cfg_wr,
    input  wire logic [PIX_W-1:0] cfg_factor,
    input  wire logic             start,
    input  wire logic             abort,
    input  wire logic [CNT_W-1:0] frame_len,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      pix_cnt,
    output logic [PIX_W-1:0]      factor
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [PIX_W-1:0] c_PIX_MAX = {PIX_W{1'b1}};

    state_t              r_state;
    logic [PIX_W-1:0]    r_factor;
    logic [CNT_W-1:0]    r_len;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_out_valid;
    logic [PIX_W-1:0]    r_out_pixel;
    logic                r_done;

    logic                w_in_ready;
    logic                w_xfer;
    logic [2*PIX_W-1:0]  w_prod;
    logic [PIX_W-1:0]    w_sat;
    logic [CNT_W-1:0]    w_cnt_nxt;

    // A new pixel may enter when the output slot is empty or is being
    // emptied in this same cycle. This allows one pixel per cycle.
    assign w_in_ready = (r_state == S_RUN) && (!r_out_valid || px.out_ready);
    assign w_xfer     = px.in_valid && w_in_ready;

    // Full-width product. Any bit set above PIX_W means overflow.
    assign w_prod    = {{PIX_W{1'b0}}, px.in_pixel} * {{PIX_W{1'b0}}, r_factor};
    assign w_sat     = (|w_prod[2*PIX_W-1:PIX_W]) ? c_PIX_MAX : w_prod[PIX_W-1:0];
    assign w_cnt_nxt = r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_factor    <= PIX_W'(SCALE_RST);
            r_len       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_pixel <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                // abort wins over everything. Any offered pixel and the
                // pending output are dropped. The factor is kept.
                r_state     <= S_IDLE;
                r_out_valid <= 1'b0;
                r_cnt       <= '0;
            end else begin
                // Output register: load on transfer, otherwise drain on ready.
                if (w_xfer) begin
                    r_out_pixel <= w_sat;
                    r_out_valid <= 1'b1;
                end else if (px.out_ready) begin
                    r_out_valid <= 1'b0;
                end

                case (r_state)
                    S_IDLE: begin
                        // The factor is written on the same edge that
                        // starts a frame, so that frame uses the new value.
                        if (cfg_wr) begin
                            r_factor <= cfg_factor;
                        end
                        if (start && (frame_len != '0)) begin
                            r_state <= S_RUN;
                            r_len   <= frame_len;
                            r_cnt   <= '0;
                        end
                    end
                    S_RUN: begin
                        if (w_xfer) begin
                            r_cnt <= w_cnt_nxt;
                            if (w_cnt_nxt == r_len) begin
                                r_state <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (r_out_valid && px.out_ready) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign px.in_ready  = w_in_ready;
    assign px.out_valid = r_out_valid;
    assign px.out_pixel = r_out_pixel;
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign pix_cnt      = r_cnt;
    assign factor       = r_factor;

endmodule
`default_nettype wire

// File: doc/scale_ctrl.md
SCALE_CTRL -- requirements
Module: scale_ctrl

Interface
REQ-001 Parameter PIX_W, default 8, pixel width in bits.
REQ-002 Parameter CNT_W, default 16, width of the frame-length field and pixel counter.
REQ-003 Parameter SCALE_RST, default 2, scale factor loaded at reset.
REQ-004 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low (clk, rst_n).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 cfg_wr  input  1  write strobe for scale factor.
REQ-008 cfg_factor  input  PIX_W  new scale factor.
REQ-009 start  input  1  single-cycle frame start request.
REQ-010 abort  input  1  synchronous frame abort.
REQ-011 frame_len  input  CNT_W  pixels per frame, sampled on accepted start.
REQ-012 in_valid / in_ready  input / output  1 each  input pixel handshake.
REQ-013 in_pixel  input  PIX_W  input pixel.
REQ-014 out_valid / out_ready  output / input  1 each  output pixel handshake.
REQ-015 out_pixel  output  PIX_W  scaled, saturated pixel.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 done  output  1  one-cycle pulse at normal frame completion.
REQ-018 pix_cnt  output  CNT_W  input pixels accepted in the current frame.
REQ-019 factor  output  PIX_W  currently active scale factor.

Function
REQ-020 FSM states SHALL be IDLE, RUN, DRAIN.
REQ-021 IDLE->RUN on start=1 with frame_len!=0 and abort=0; latch frame_len, clear pix_cnt.
REQ-022 start with frame_len==0 SHALL be ignored: stay in IDLE, no done pulse.
REQ-023 start outside IDLE SHALL be ignored.
REQ-024 cfg_wr SHALL update factor only in IDLE; in RUN/DRAIN it is ignored, so factor is constant for a whole frame.
REQ-025 cfg_wr and an accepted start in the same cycle: the new factor is written and used for that frame.
REQ-026 in_ready = (state==RUN) && (!out_valid || out_ready), combinational.
REQ-027 Input transfer on in_valid && in_ready; the output register loads out_pixel next edge and sets out_valid (1-cycle latency).
REQ-028 out_pixel = min(in_pixel * factor, 2^PIX_W - 1), full 2*PIX_W-bit product then saturated; factor 0 yields 0.
REQ-029 out_valid SHALL hold, with out_pixel stable, until out_ready=1; it clears on out_ready when no new load occurs in that cycle.
REQ-030 pix_cnt SHALL increment by 1 per input transfer.
REQ-031 On the transfer that makes pix_cnt equal the latched frame_len, RUN->DRAIN; no further input is accepted.
REQ-032 DRAIN->IDLE when out_valid && out_ready; done=1 in the following cycle only.
REQ-033 abort=1 in any state: next state IDLE, out_valid cleared, pix_cnt cleared, no done pulse, factor unchanged.
REQ-034 abort has priority over start, cfg_wr, and any same-cycle transfer; a pixel offered in an abort cycle is discarded.
REQ-035 Back-to-back throughput SHALL be one pixel per cycle when out_ready is held high.

Reset
REQ-036 While rst_n=0: state IDLE, factor=SCALE_RST, pix_cnt=0, out_valid=0, out_pixel=0, done=0, busy=0, in_ready=0.
REQ-037 Reset SHALL take effect immediately, including mid-frame; the pending output is lost, and no done is issued.
REQ-038 Reset release SHALL be synchronised externally; the first active edge after deassertion behaves as IDLE.

Verification
REQ-039 Reset, then frame_len=4, pixels 10,20,30,40, out_ready=1 -> outputs 20,40,60,80 on consecutive cycles, each one cycle after input; done once, 1 cycle after the last output handshake.
REQ-040 cfg_factor=3 in IDLE, pixel 100 -> out_pixel 255 (saturated); factor=0, pixel 200 -> 0.
REQ-041 out_ready=0 for 5 cycles mid-frame -> in_ready=0, out_pixel/out_valid stable, no pixel lost or duplicated, pix_cnt frozen.
REQ-042 cfg_wr=1, cfg_factor=5 during RUN -> factor stays 2 for the frame; factor=5 only if written after returning to IDLE.
REQ-043 abort at pix_cnt=2 of a 4-pixel frame with out_valid=1 -> next cycle IDLE, out_valid=0, pix_cnt=0, done=0; an abort+start same cycle -> stays IDLE.
REQ-044 start with frame_len=0 -> busy stays 0, no done; rst_n low mid-frame -> all outputs at reset values asynchronously.
